// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter: shares one single-port, word-addressed memory slave
// between the instruction-fetch bus (IBus, read-only) and the data bus (DBus).
// Grant is combinational while idle. The bus stays locked to its owner while
// the slave stalls. Read data returns one cycle after acceptance and is
// steered to the master that issued the read.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// between simultaneous idle requests. Without it, DBus has fixed priority.
module ibus_dbus_arbiter #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [ADDR_W-1:0]     i_IBus_Address,
   input  logic                  i_IBus_Read,
   output logic                  o_IBus_WaitReq,
   output logic [DATA_W-1:0]     o_IBus_ReadData,
   output logic                  o_IBus_ReadDataValid,
   input  logic [ADDR_W-1:0]     i_DBus_Address,
   input  logic                  i_DBus_Read,
   input  logic                  i_DBus_Write,
   input  logic [DATA_W-1:0]     i_DBus_WriteData,
   input  logic [DATA_W/8-1:0]   i_DBus_ByteEnable,
   output logic                  o_DBus_WaitReq,
   output logic [DATA_W-1:0]     o_DBus_ReadData,
   output logic                  o_DBus_ReadDataValid,
   output logic [ADDR_W-1:0]     o_Mem_Address,
   output logic                  o_Mem_Read,
   output logic                  o_Mem_Write,
   output logic [DATA_W-1:0]     o_Mem_WriteData,
   output logic [DATA_W/8-1:0]   o_Mem_ByteEnable,
   input  logic [DATA_W-1:0]     i_Mem_ReadData,
   input  logic                  i_Mem_WaitReq
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

   state_t state_q;
   logic   last_gnt_q;   // 0 = IBus, 1 = DBus was the most recent accepted owner
   logic   rd_owner_q;   // 0 = IBus, 1 = DBus owns the read in flight
   logic   rd_pend_q;    // a read was accepted last cycle; data is on i_Mem_ReadData

   logic   i_req, d_req;
   logic   gnt_i, gnt_d;
   logic   own_req, own_rd;
   logic   accept;

   assign i_req = i_IBus_Read;
   assign d_req = i_DBus_Read | i_DBus_Write;

`ifndef ARB_ROUND_ROBIN_EN
   // Fixed priority leaves the last-grant history unused; keep it visible to lint.
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt_q;
`endif

   // Select this cycle's owner: a locked owner keeps the bus, otherwise arbitrate.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (!i_Rst) begin
         case (state_q)
            LOCK_I:  gnt_i = 1'b1;
            LOCK_D:  gnt_d = 1'b1;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
               if (i_req && d_req) begin
                  gnt_i = last_gnt_q;
                  gnt_d = ~last_gnt_q;
               end else begin
                  gnt_i = i_req;
                  gnt_d = d_req;
               end
`else
               gnt_d = d_req;
               gnt_i = i_req & ~d_req;
`endif
            end
         endcase
      end
   end

   // Owner's request and the resulting handshake with the slave.
   always_comb begin
      own_req = 1'b0;
      own_rd  = 1'b0;
      if (gnt_i) begin
         own_req = i_req;
         own_rd  = i_IBus_Read;
      end else if (gnt_d) begin
         own_req = d_req;
         own_rd  = i_DBus_Read;
      end
      accept = own_req & ~i_Mem_WaitReq;
   end

   // Drive the slave port from the owner; DBus fields are the idle default.
   always_comb begin
      o_Mem_Address    = i_DBus_Address;
      o_Mem_WriteData  = i_DBus_WriteData;
      o_Mem_ByteEnable = i_DBus_ByteEnable;
      o_Mem_Read       = 1'b0;
      o_Mem_Write      = 1'b0;
      if (gnt_i) begin
         o_Mem_Address    = i_IBus_Address;
         o_Mem_ByteEnable = {BE_W{1'b1}};
         o_Mem_Read       = i_IBus_Read;
      end else if (gnt_d) begin
         o_Mem_Read       = i_DBus_Read;
         o_Mem_Write      = i_DBus_Write;
      end
   end

   // Stall handshake: only the owner sees the slave's stall, everyone else waits.
   always_comb begin
      o_IBus_WaitReq = gnt_i ? i_Mem_WaitReq : 1'b1;
      o_DBus_WaitReq = gnt_d ? i_Mem_WaitReq : 1'b1;
   end

   // Read return: the slave word goes to both buses, qualified by the owner's valid.
   always_comb begin
      o_IBus_ReadData      = i_Mem_ReadData;
      o_DBus_ReadData      = i_Mem_ReadData;
      o_IBus_ReadDataValid = rd_pend_q & ~rd_owner_q & ~i_Rst;
      o_DBus_ReadDataValid = rd_pend_q &  rd_owner_q & ~i_Rst;
   end

   // Lock FSM, grant history and read-in-flight tracking.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         rd_owner_q <= 1'b0;
         rd_pend_q  <= 1'b0;
      end else begin
         rd_pend_q <= accept & own_rd;
         if (accept) begin
            last_gnt_q <= gnt_d;
            if (own_rd) rd_owner_q <= gnt_d;
         end
         case (state_q)
            IDLE: begin
               if (own_req && i_Mem_WaitReq) state_q <= gnt_d ? LOCK_D : LOCK_I;
            end
            default: begin
               // Leave the lock on acceptance, or if the owner dropped its request.
               if (!own_req || !i_Mem_WaitReq) state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
